hdng_err_gen: RTL and testbench
===============================

Name: hdng_err_gen

Overview:
- Producer side of the heading-control error interface; drives err_sat/hdng_vld into the PID P/I/D terms.
- Calibrates the gyro yaw-rate offset, integrates the offset-compensated yaw rate into the actual heading, and subtracts the desired heading.
- Saturates the 12-bit heading error to 10 bits and emits one err_sat value per yaw sample, qualified by a 1-cycle hdng_vld pulse.

Parameters:
- CAL_LOG2, 11, log2 of the number of yaw samples averaged during calibration (range 1..12)
- HDNG_SHIFT, 11, right-shift from the heading accumulator to the 12-bit heading; accumulator width is 12+HDNG_SHIFT
- DEADBAND, 4, magnitude threshold used only when GYRO_DEADBAND_EN is defined

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- strt_cal  in  1  pulse; starts or restarts calibration
- yaw_vld  in  1  new yaw_rt sample this cycle
- yaw_rt  in  16 signed  raw gyro yaw rate
- dsrd_hdng  in  12 signed  desired heading, sampled on the cycle yaw_vld is high
- cal_done  out  1  level; high while in RUN
- actl_hdng  out  12 signed  integrated heading, registered
- err_sat  out  10 signed  saturated heading error
- hdng_vld  out  1  1-cycle pulse qualifying err_sat

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=IDLE, all accumulators 0, offset 0, actl_hdng 0, err_sat 0, hdng_vld 0, cal_done 0.
- States:
  - IDLE: outputs held. strt_cal -> CAL.
  - CAL: clears the sample counter and the (16+CAL_LOG2)-bit signed sum on entry. Each yaw_vld adds sign-extended yaw_rt and increments the counter. On the 2^CAL_LOG2-th sample, offset <= sum >>> CAL_LOG2 (arithmetic shift, floor), heading accumulator <= 0, then -> RUN.
  - RUN: cal_done=1.
- strt_cal in CAL or RUN restarts CAL:
  - counter and sum cleared; heading accumulator cleared; err_sat <= 0; cal_done drops the next cycle.
  - A yaw_vld in the same cycle as strt_cal is ignored.
  - strt_cal in IDLE ignores a simultaneous yaw_vld.
- hdng_vld is never asserted outside RUN. err_sat and actl_hdng hold their values between samples.
- RUN pipeline, sample at cycle N:
  - N+1: comp = yaw_rt - offset (17-bit signed); hdng_acc <= hdng_acc + sign-extended comp. hdng_acc wraps modulo 2^(12+HDNG_SHIFT); heading is angular, so no saturation.
  - N+1: actl_hdng = hdng_acc[HDNG_SHIFT +: 12], i.e. a wrapped bit-slice, registered from the updated value. dsrd_hdng is captured at N.
  - N+2: err12 = actl_hdng - dsrd_captured, 12-bit wrapping subtraction (shortest-angle error). err_sat <= err12 clamped to [-512, 511]. hdng_vld=1 for exactly this cycle.
- Back-to-back yaw_vld on consecutive cycles is supported: one hdng_vld per sample, latency 2.
- The last calibration sample produces no hdng_vld. The first RUN sample does.
- Asynchronous reset mid-CAL or mid-RUN returns to IDLE with all reset values.

Optional Feature:
- Macro GYRO_DEADBAND_EN.
- Defined: in RUN, if |comp| <= DEADBAND, comp is forced to 0 before accumulation. Calibration is unaffected.
- Undefined: no deadband logic; comp is always accumulated.

Decomposition:
- Package hdng_pkg:
  - state enum {IDLE, CAL, RUN}
  - localparams HDNG_W=12, ERR_W=10, YAW_W=16
  - ERR_MAX=511, ERR_MIN=-512
- One sub-module, yaw_offset_cal: owns the counter, sum and offset register. Interface: clr, yaw_vld, yaw_rt, offset, done pulse.
- The FSM, integrator and saturator stay in hdng_err_gen.

Test Plan:
- Calibration (CAL_LOG2=3): strt_cal, then 8 samples yaw_rt=100 -> cal_done rises; offset=100; no hdng_vld during CAL. Repeat with 8 samples of -3 -> offset=-3.
- Integration (HDNG_SHIFT=11, offset=100, dsrd_hdng=0): 10 samples yaw_rt=2148, 1 cycle apart -> 10 hdng_vld pulses, each 2 cycles after its sample; actl_hdng=1..10; err_sat=1..10.
- Saturation: actl_hdng=0, dsrd_hdng=-600 -> err_sat=511. dsrd_hdng=600 -> err_sat=-512. dsrd_hdng=-300 -> err_sat=300.
- Wrap: actl_hdng=-2048, dsrd_hdng=2047 -> err12=1, err_sat=1. Heading accumulator overflows from 2047 to -2048 with no glitch on hdng_vld.
- Restart and reset:
  - strt_cal mid-RUN with a simultaneous yaw_vld -> no hdng_vld; err_sat=0; cal_done=0 next cycle; recalibrates over 8 new samples.
  - rst_n low mid-CAL -> all outputs 0 immediately; state IDLE.
- GYRO_DEADBAND_EN defined, DEADBAND=4, offset=100: yaw_rt=103 -> actl_hdng unchanged. yaw_rt=105 -> accumulator +5.

Source files
------------

// File: rtl/hdng_pkg.sv
// ---------------------------------------------------------------------------
// hdng_pkg
// Shared types and constants for the heading-error generator.
//   state_t  : controller states (IDLE, CAL, RUN)
//   HDNG_W   : heading width (12-bit signed, wraps as an angle)
//   ERR_W    : saturated error width (10-bit signed)
//   YAW_W    : raw gyro yaw-rate width (16-bit signed)
//   ERR_MAX / ERR_MIN : clamp limits for the saturated error
//   sat_err  : clamps a 12-bit heading error into the 10-bit error range
// ---------------------------------------------------------------------------
package hdng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int HDNG_W  = 12;
  localparam int ERR_W   = 10;
  localparam int YAW_W   = 16;
  localparam int ERR_MAX = 511;
  localparam int ERR_MIN = -512;

  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [HDNG_W-1:0] e);
    logic signed [ERR_W-1:0] r;
    if (e > ERR_MAX)      r = ERR_W'(ERR_MAX);
    else if (e < ERR_MIN) r = ERR_W'(ERR_MIN);
    else                  r = ERR_W'(e);
    return r;
  endfunction

endpackage

// File: rtl/hdng_err_gen_cal.sv
// ---------------------------------------------------------------------------
// yaw_offset_cal
// Averages 2^CAL_LOG2 yaw-rate samples to estimate the gyro zero-rate offset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clears the sample counter and running sum (offset is kept)
//   yaw_vld    : sample qualifier; the parent gates this to the CAL state
//   yaw_rt     : raw signed yaw rate
//   offset     : registered offset estimate (floor of the average)
//   done       : combinational pulse on the final sample of a calibration
// ---------------------------------------------------------------------------
module yaw_offset_cal
  import hdng_pkg::*;
#(
  parameter int CAL_LOG2 = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    yaw_vld,
  input  logic signed [YAW_W-1:0] yaw_rt,
  output logic signed [YAW_W-1:0] offset,
  output logic                    done
);

  localparam int SUM_W = YAW_W + CAL_LOG2;

  logic [CAL_LOG2-1:0]     cnt;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_nxt;

  // The counter is all-ones exactly when the incoming sample is the last one.
  always_comb begin
    sum_nxt = sum + SUM_W'(yaw_rt);
    done    = yaw_vld && !clr && (&cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sum    <= '0;
      offset <= '0;
    end else if (clr) begin
      cnt <= '0;
      sum <= '0;
    end else if (yaw_vld) begin
      cnt <= cnt + 1'b1;
      if (done) begin
        // Arithmetic shift gives the floor of the average; the counter
        // wraps to zero on its own, the sum restarts for any later run.
        offset <= YAW_W'(sum_nxt >>> CAL_LOG2);
        sum    <= '0;
      end else begin
        sum <= sum_nxt;
      end
    end
  end

endmodule

// File: rtl/hdng_err_gen.sv
// ---------------------------------------------------------------------------
// hdng_err_gen
// Calibrates the gyro offset, integrates offset-compensated yaw rate into the
// actual heading, subtracts the desired heading and saturates the error.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   strt_cal   : pulse, starts or restarts calibration
//   yaw_vld    : a new yaw_rt sample is present this cycle
//   yaw_rt     : raw signed gyro yaw rate (16 bits)
//   dsrd_hdng  : desired heading (12 bits signed), sampled with yaw_vld
//   cal_done   : high while running (calibration complete)
//   actl_hdng  : integrated heading (12 bits signed), registered
//   err_sat    : saturated heading error (10 bits signed)
//   hdng_vld   : one-cycle pulse qualifying err_sat, two cycles after a sample
// Build option: define GYRO_DEADBAND_EN to zero small compensated rates
// (|comp| <= DEADBAND) before integration while running.
// ---------------------------------------------------------------------------
module hdng_err_gen
  import hdng_pkg::*;
#(
  parameter int CAL_LOG2   = 11,
  parameter int HDNG_SHIFT = 11,
  parameter int DEADBAND   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     strt_cal,
  input  logic                     yaw_vld,
  input  logic signed [YAW_W-1:0]  yaw_rt,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic                     cal_done,
  output logic signed [HDNG_W-1:0] actl_hdng,
  output logic signed [ERR_W-1:0]  err_sat,
  output logic                     hdng_vld
);

  localparam int ACC_W = HDNG_W + HDNG_SHIFT;

  state_t                   state;
  logic signed [ACC_W-1:0]  hdng_acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [HDNG_W-1:0] dsrd_cap;
  logic signed [HDNG_W-1:0] err12;
  logic                     s1_vld;
  logic                     cal_vld;
  logic                     cal_last;
  logic signed [YAW_W-1:0]  offset;
  logic signed [YAW_W:0]    comp;
  logic signed [YAW_W:0]    comp_db;

  // Only samples taken while calibrating (and not coinciding with a restart)
  // feed the offset estimator.
  assign cal_vld = (state == CAL) && yaw_vld && !strt_cal;

  yaw_offset_cal #(
    .CAL_LOG2(CAL_LOG2)
  ) u_cal (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (strt_cal),
    .yaw_vld(cal_vld),
    .yaw_rt (yaw_rt),
    .offset (offset),
    .done   (cal_last)
  );

  // One extra bit keeps yaw_rt - offset exact for any pair of 16-bit values.
  assign comp = {yaw_rt[YAW_W-1], yaw_rt} - {offset[YAW_W-1], offset};

`ifdef GYRO_DEADBAND_EN
  always_comb begin
    comp_db = comp;
    if ((comp <= DEADBAND) && (comp >= -DEADBAND)) comp_db = '0;
  end
`else
  localparam int unused_deadband = DEADBAND;
  assign comp_db = comp;
`endif

  // The accumulator wraps freely: heading is an angle, so overflow is the
  // intended modular behaviour, and the same holds for the 12-bit error.
  assign acc_nxt = hdng_acc + ACC_W'(comp_db);
  assign err12   = actl_hdng - dsrd_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdng_acc  <= '0;
      dsrd_cap  <= '0;
      s1_vld    <= 1'b0;
      cal_done  <= 1'b0;
      actl_hdng <= '0;
      err_sat   <= '0;
      hdng_vld  <= 1'b0;
    end else begin
      hdng_vld <= 1'b0;
      s1_vld   <= 1'b0;
      case (state)
        IDLE: begin
          if (strt_cal) state <= CAL;
        end
        CAL: begin
          if (strt_cal) begin
            hdng_acc <= '0;
            err_sat  <= '0;
          end else if (cal_last) begin
            hdng_acc <= '0;
            cal_done <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (strt_cal) begin
            // A pending stage-1 sample is dropped so no pulse leaks into CAL.
            state    <= CAL;
            cal_done <= 1'b0;
            hdng_acc <= '0;
            err_sat  <= '0;
          end else begin
            if (yaw_vld) begin
              hdng_acc  <= acc_nxt;
              actl_hdng <= acc_nxt[HDNG_SHIFT +: HDNG_W];
              dsrd_cap  <= dsrd_hdng;
            end
            s1_vld <= yaw_vld;
            if (s1_vld) begin
              err_sat  <= sat_err(err12);
              hdng_vld <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdng_err_gen.sv
// ---------------------------------------------------------------------------
// tb_hdng_err_gen
// Directed-vector bench for hdng_err_gen (CAL_LOG2=3, HDNG_SHIFT=11). Each
// sample that should produce an error word pushes its expected err_sat and
// due cycle into a scoreboard queue; a negedge monitor pops and compares on
// every hdng_vld pulse, and flags pulses nobody asked for.
// ---------------------------------------------------------------------------
module tb_hdng_err_gen;

  logic               clk;
  logic               rst_n;
  logic               strt_cal;
  logic               yaw_vld;
  logic signed [15:0] yaw_rt;
  logic signed [11:0] dsrd_hdng;
  logic               cal_done;
  logic signed [11:0] actl_hdng;
  logic signed [9:0]  err_sat;
  logic               hdng_vld;

  typedef struct {
    int err;
    int due;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;

  hdng_err_gen #(
    .CAL_LOG2  (3),
    .HDNG_SHIFT(11),
    .DEADBAND  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cal (strt_cal),
    .yaw_vld  (yaw_vld),
    .yaw_rt   (yaw_rt),
    .dsrd_hdng(dsrd_hdng),
    .cal_done (cal_done),
    .actl_hdng(actl_hdng),
    .err_sat  (err_sat),
    .hdng_vld (hdng_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests = tests + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one cycle of inputs (called at posedge+1) and returns at the
  // next posedge+1 with the strobes released, so calls chain back-to-back.
  task automatic applyStimulus(input logic s_cal, input logic v, input int yr, input int dh,
                               input logic expect_out, input int exp_err);
    exp_t e;
    strt_cal  = s_cal;
    yaw_vld   = v;
    yaw_rt    = 16'(yr);
    dsrd_hdng = 12'(dh);
    if (expect_out) begin
      e.err = exp_err;
      e.due = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    strt_cal = 1'b0;
    yaw_vld  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference error: 12-bit wrapping difference clamped to [-512, 511].
  function automatic int expErr(input int actl, input int dsrd);
    logic signed [11:0] d;
    int r;
    d = 12'(actl - dsrd);
    r = d;
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && hdng_vld) begin
      if (sb.size() == 0) begin
        tests  = tests + 1;
        errors = errors + 1;
        $display("[TB] FAIL unexpected_hdng_vld: got pulse with err_sat %0d, expected none (cycle %0d)",
                 err_sat, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("err_sat", int'(err_sat), e.err);
        checkOutput("latency", cyc, e.due);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    strt_cal  = 1'b0;
    yaw_vld   = 1'b0;
    yaw_rt    = '0;
    dsrd_hdng = '0;
    #22;
    checkOutput("reset_actl_hdng", int'(actl_hdng), 0);
    checkOutput("reset_err_sat", int'(err_sat), 0);
    checkOutput("reset_hdng_vld", int'(hdng_vld), 0);
    checkOutput("reset_cal_done", int'(cal_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Calibrate on 8 samples of 100: offset becomes 100.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 100, 0, 0, 0);
    checkOutput("cal_done_after_cal", int'(cal_done), 1);

    // 2148 - 100 = 2048 = one heading unit per sample, back-to-back.
    for (int k = 1; k <= 10; k++) applyStimulus(0, 1, 2148, 0, 1, k);
    idleCycles(3);
    checkOutput("actl_after_integrate", int'(actl_hdng), 10);

    // Bring heading back to 0, then exercise both clamp limits and a
    // pass-through value.
    applyStimulus(0, 1, -20380, -600, 1, 511);
    idleCycles(3);
    checkOutput("actl_zero", int'(actl_hdng), 0);
    applyStimulus(0, 1, 100, 600, 1, -512);
    applyStimulus(0, 1, 100, -300, 1, 300);
    idleCycles(3);

    // Walk heading down by 16 per sample to -2048 against dsrd 2047;
    // the final sample gives err12 = 1.
    for (int k = 1; k <= 128; k++) applyStimulus(0, 1, -32668, 2047, 1, expErr(-16 * k, 2047));
    idleCycles(3);
    checkOutput("actl_min", int'(actl_hdng), -2048);
    applyStimulus(0, 1, -1948, 2047, 1, 0);
    idleCycles(3);
    checkOutput("actl_wrap_down", int'(actl_hdng), 2047);
    applyStimulus(0, 1, 2148, 2047, 1, 1);
    idleCycles(3);
    checkOutput("actl_wrap_up", int'(actl_hdng), -2048);

    // Restart mid-RUN with a simultaneous sample: no pulse, error cleared.
    applyStimulus(1, 1, 2148, 0, 0, 0);
    checkOutput("restart_cal_done", int'(cal_done), 0);
    checkOutput("restart_err_sat", int'(err_sat), 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, -3, 0, 0, 0);
    checkOutput("recal_done", int'(cal_done), 1);
    applyStimulus(0, 1, 2045, 0, 1, 1);
    idleCycles(3);
    checkOutput("actl_after_recal", int'(actl_hdng), 1);

    // Asynchronous reset in the middle of calibration.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 100, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_actl", int'(actl_hdng), 0);
    checkOutput("async_rst_err", int'(err_sat), 0);
    checkOutput("async_rst_vld", int'(hdng_vld), 0);
    checkOutput("async_rst_cal_done", int'(cal_done), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores samples; a sample alongside strt_cal is not counted.
    applyStimulus(0, 1, 2148, 0, 0, 0);
    applyStimulus(1, 1, 5000, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 100, 0, 0, 0);
    checkOutput("cal_done_after_7", int'(cal_done), 0);
    applyStimulus(0, 1, 100, 0, 0, 0);
    checkOutput("cal_done_after_8", int'(cal_done), 1);
    applyStimulus(0, 1, 2148, 0, 1, 1);
    idleCycles(3);
    checkOutput("actl_after_reset_cal", int'(actl_hdng), 1);

    // Every queued expectation must have been consumed by a pulse.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
